// File: rtl/sd_pkg.sv
// Shared types and constants for the SD DAT receive path.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_DATA       = 3'd2,
        ST_CRC        = 3'd3,
        ST_END        = 3'd4,
        ST_DONE       = 3'd5
    } sd_state_e;

    localparam logic [15:0] SD_CRC16_POLY = 16'h1021;
    localparam int          SD_DAT_W      = 4;
    localparam int          SD_CRC_BITS   = 16;

    // One serial CRC16-CCITT step, MSB-first.
    function automatic logic [15:0] sd_crc16_next(input logic [15:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? SD_CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc16_line.sv
// Bit-serial CRC16 for a single DAT line, with synchronous clear and enable.
module sd_crc16_line
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_r;

    // CRC register: clear wins over shift, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_r <= 16'h0000;
        end else if (clr) begin
            crc_r <= 16'h0000;
        end else if (en) begin
            crc_r <= sd_crc16_next(crc_r, din);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/sd_dat_rx.sv
// SD 4-bit DAT block receiver: start-bit wait, nibble-to-byte assembly,
// per-line CRC16 check, end-bit check and a single completion pulse.
module sd_dat_rx
    import sd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [3:0]  i_sd_data,
    input  logic [9:0]  i_buf_len,
    output logic [7:0]  o_data,
    output logic        o_data_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_crc_ok,
    output logic        o_timeout
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

    sd_state_e         state_r;
    sd_state_e         next_state_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [9:0]        byte_cnt_r;
    logic              nib_r;
    logic [3:0]        hi_nib_r;
    logic [3:0]        crc_bit_r;
    logic              err_r;

    logic              arm_s;
    logic              crc_en_s;
    logic              byte_done_s;
    logic              crc_mis_s;
    logic              end_bad_s;
    logic              done_s;
    logic              timeout_s;
    logic [3:0]        exp_bits_s;
    logic [15:0]       crc_line_s [SD_DAT_W];

    assign arm_s = (state_r == ST_IDLE) && i_start && (i_buf_len != 10'd0);

    for (genvar k = 0; k < SD_DAT_W; k++) begin : g_crc
        sd_crc16_line u_crc (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (arm_s),
            .en    (crc_en_s),
            .din   (i_sd_data[k]),
            .crc   (crc_line_s[k])
        );
        // CRC registers stop shifting at DATA exit, so they are already frozen here.
        assign exp_bits_s[k] = crc_line_s[k][4'd15 - crc_bit_r];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arm_s) next_state_s = ST_WAIT_START;
                else       next_state_s = ST_IDLE;
            end
            ST_WAIT_START: begin
                if (i_sd_data == 4'h0)            next_state_s = ST_DATA;
                else if (wait_cnt_r == WAIT_LIMIT) next_state_s = ST_DONE;
                else                              next_state_s = ST_WAIT_START;
            end
            ST_DATA: begin
                if (nib_r && (byte_cnt_r == 10'd1)) next_state_s = ST_CRC;
                else                               next_state_s = ST_DATA;
            end
            ST_CRC: begin
                if (crc_bit_r == 4'd15) next_state_s = ST_END;
                else                    next_state_s = ST_CRC;
            end
            ST_END:  next_state_s = ST_DONE;
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Per-state strobes feeding the datapath and output registers.
    always_comb begin
        crc_en_s    = 1'b0;
        byte_done_s = 1'b0;
        crc_mis_s   = 1'b0;
        end_bad_s   = 1'b0;
        case (state_r)
            ST_DATA: begin
                crc_en_s    = 1'b1;
                byte_done_s = nib_r;
            end
            ST_CRC:  crc_mis_s = (i_sd_data != exp_bits_s);
            ST_END:  end_bad_s = (i_sd_data != 4'hF);
            default: begin
                crc_en_s    = 1'b0;
                byte_done_s = 1'b0;
            end
        endcase
        done_s    = (next_state_s == ST_DONE);
        timeout_s = (state_r == ST_WAIT_START) && (next_state_s == ST_DONE);
    end

    // Counters, nibble assembly and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
            byte_cnt_r <= 10'd0;
            nib_r      <= 1'b0;
            hi_nib_r   <= 4'h0;
            crc_bit_r  <= 4'd0;
            err_r      <= 1'b0;
        end else if (arm_s) begin
            wait_cnt_r <= '0;
            byte_cnt_r <= i_buf_len;
            nib_r      <= 1'b0;
            hi_nib_r   <= 4'h0;
            crc_bit_r  <= 4'd0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_WAIT_START: begin
                    if (wait_cnt_r != WAIT_LIMIT) wait_cnt_r <= wait_cnt_r + 1'b1;
                    else                          wait_cnt_r <= wait_cnt_r;
                end
                ST_DATA: begin
                    nib_r <= ~nib_r;
                    if (!nib_r) hi_nib_r   <= i_sd_data;
                    else        byte_cnt_r <= byte_cnt_r - 10'd1;
                end
                ST_CRC: begin
                    crc_bit_r <= crc_bit_r + 4'd1;
                    if (crc_mis_s) err_r <= 1'b1;
                    else           err_r <= err_r;
                end
                ST_END: begin
                    if (end_bad_s) err_r <= 1'b1;
                    else           err_r <= err_r;
                end
                default: begin
                    nib_r <= nib_r;
                end
            endcase
        end
    end

    // Registered outputs; status flags hold until the next arm.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_data       <= 8'h00;
            o_data_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_crc_ok     <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            o_data_valid <= byte_done_s;
            o_done       <= done_s;
            o_busy       <= (next_state_s != ST_IDLE);
            if (byte_done_s) o_data <= {hi_nib_r, i_sd_data};
            else             o_data <= o_data;
            if (arm_s) begin
                o_crc_ok  <= 1'b0;
                o_timeout <= 1'b0;
            end else if (done_s) begin
                o_crc_ok  <= !timeout_s && !(err_r || end_bad_s);
                o_timeout <= timeout_s;
            end else begin
                o_crc_ok  <= o_crc_ok;
                o_timeout <= o_timeout;
            end
        end
    end

endmodule

// File: tb/tb_sd_dat_rx.sv
// Randomised bench for sd_dat_rx with a cycle-indexed expectation model.
module tb_sd_dat_rx;

    localparam int T    = 16;
    localparam int MAXC = 8000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [3:0] i_sd_data = 4'hF;
    logic [9:0] i_buf_len = 10'd0;
    logic [7:0] o_data;
    logic       o_data_valid, o_busy, o_done, o_crc_ok, o_timeout;

    sd_dat_rx #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_sd_data(i_sd_data),
        .i_buf_len(i_buf_len), .o_data(o_data), .o_data_valid(o_data_valid),
        .o_busy(o_busy), .o_done(o_done), .o_crc_ok(o_crc_ok), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    bit       e_valid [MAXC];
    bit       e_done  [MAXC];
    bit       e_busy  [MAXC];
    bit       e_ok    [MAXC];
    bit       e_to    [MAXC];
    logic [7:0] e_data [MAXC];
    logic [7:0] got_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the expectation arrays.
    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            check("valid", o_data_valid, e_valid[cyc]);
            check("done", o_done, e_done[cyc]);
            check("busy", o_busy, e_busy[cyc]);
            check("crc_ok", o_crc_ok, e_ok[cyc]);
            check("timeout", o_timeout, e_to[cyc]);
            if (e_valid[cyc]) check("data", o_data, e_data[cyc]);
            if (o_data_valid === 1'b1) got_q.push_back(o_data);
        end
    end

    // CRC as remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] model_crc(input bit bits [$]);
        bit r [$];
        logic [16:0] g;
        logic [15:0] res;
        int n;
        g = 17'h11021;
        r = bits;
        n = bits.size();
        for (int i = 0; i < 16; i++) r.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            if (r[i]) begin
                for (int j = 0; j <= 16; j++) r[i + j] = r[i + j] ^ g[16 - j];
            end
        end
        for (int i = 0; i < 16; i++) res[15 - i] = r[n + i];
        return res;
    endfunction

    function automatic logic [15:0] line_crc(input logic [7:0] bytes [$], input int k);
        bit bits [$];
        foreach (bytes[i]) begin
            bits.push_back(bytes[i][k + 4]);
            bits.push_back(bytes[i][k]);
        end
        return model_crc(bits);
    endfunction

    task automatic drive(input logic [3:0] d, input logic st);
        @(posedge clk);
        #1;
        i_sd_data = d;
        i_start   = st;
    endtask

    task automatic clear_from(input int c0);
        for (int c = c0; c < MAXC; c++) begin
            e_valid[c] = 1'b0; e_done[c] = 1'b0; e_busy[c] = 1'b0;
            e_ok[c] = 1'b0; e_to[c] = 1'b0;
        end
    endtask

    // gap < 0: never send a start bit. abort_after >= 0: reset after that data nibble.
    task automatic run_block(input int len, input logic [7:0] bytes [$], input int gap,
                             input int flip_line, input int flip_bit, input logic [3:0] end_nib,
                             input int abort_after, input bit poke_busy);
        int a, w, s, d;
        logic [15:0] crcs [4];
        logic [3:0] nib;
        bit ok;
        i_buf_len = 10'(len);
        drive(4'hF, 1'b1);
        a = cyc;
        w = a + 1;
        for (int c = a + 1; c < MAXC; c++) begin e_ok[c] = 1'b0; e_to[c] = 1'b0; end
        if (gap < 0) begin
            d = w + T + 1;
            for (int c = w; c <= d; c++) e_busy[c] = 1'b1;
            e_done[d] = 1'b1;
            for (int c = d; c < MAXC; c++) e_to[c] = 1'b1;
            for (int c = w; c <= d; c++) drive(4'hF, 1'b0);
            return;
        end
        s = w + gap;
        d = s + 2 * len + 18;
        for (int k = 0; k < 4; k++) crcs[k] = line_crc(bytes, k);
        if (flip_line >= 0) crcs[flip_line][flip_bit] = ~crcs[flip_line][flip_bit];
        ok = (flip_line < 0) && (end_nib == 4'hF);
        for (int c = w; c <= d; c++) e_busy[c] = 1'b1;
        for (int n = 0; n < len; n++) begin
            e_valid[s + 2 * n + 3] = 1'b1;
            e_data[s + 2 * n + 3]  = bytes[n];
        end
        e_done[d] = 1'b1;
        for (int c = d; c < MAXC; c++) e_ok[c] = ok;
        for (int g = 0; g < gap; g++) drive(4'hF, 1'b0);
        drive(4'h0, 1'b0);
        for (int n = 0; n < 2 * len; n++) begin
            nib = (n % 2 == 0) ? bytes[n / 2][7:4] : bytes[n / 2][3:0];
            drive(nib, 1'b0);
            if (poke_busy && n == 2) begin i_start = 1'b1; i_buf_len = 10'd3; end
            if (n == abort_after) begin
                drive(4'hF, 1'b0);
                rst_n = 1'b0;
                clear_from(cyc + 1);
                drive(4'hF, 1'b0);
                rst_n = 1'b1;
                @(negedge clk);
                check("abort_data", o_data, 8'h00);
                check("abort_busy", o_busy, 1'b0);
                check("abort_done", o_done, 1'b0);
                return;
            end
        end
        for (int i = 0; i < 16; i++)
            drive({crcs[3][15 - i], crcs[2][15 - i], crcs[1][15 - i], crcs[0][15 - i]}, 1'b0);
        drive(end_nib, 1'b0);
        drive(4'hF, 1'b0);
    endtask

    initial begin
        logic [7:0] bq [$];
        logic [7:0] str [$];
        bit bits [$];
        int len;
        bit one [$];

        // Pin the reference model against known CRC values.
        str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        foreach (str[i]) for (int b = 7; b >= 0; b--) bits.push_back(str[i][b]);
        check("model_123456789", model_crc(bits), 16'h31C3);
        one.push_back(1'b1);
        check("model_single_one", model_crc(one), 16'h1021);

        drive(4'hF, 1'b0);
        drive(4'hF, 1'b0);
        chk_en = 1'b1;
        drive(4'hF, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_data", o_data, 8'h00);
        check("reset_ok", o_crc_ok, 1'b0);

        // Counting nibbles 0..F, start bit two cycles after arm.
        bq = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        got_q.delete();
        run_block(8, bq, 1, -1, 0, 4'hF, -1, 1'b0);
        @(negedge clk);
        check("s1_ok", o_crc_ok, 1'b1);
        check("s1_nbytes", got_q.size(), 8);
        check("s1_first", got_q[0], 8'h01);
        check("s1_last", got_q[7], 8'hEF);

        // All-zero block with all-zero CRC.
        bq = '{8'h00, 8'h00, 8'h00, 8'h00};
        check("model_zero", line_crc(bq, 0), 16'h0000);
        run_block(4, bq, 3, -1, 0, 4'hF, -1, 1'b0);
        @(negedge clk);
        check("s2_ok", o_crc_ok, 1'b1);

        // Flipped CRC bit on DAT2.
        bq = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        got_q.delete();
        run_block(8, bq, 1, 2, 9, 4'hF, -1, 1'b0);
        @(negedge clk);
        check("s3_ok", o_crc_ok, 1'b0);
        check("s3_to", o_timeout, 1'b0);
        check("s3_nbytes", got_q.size(), 8);

        // Bad end bit.
        run_block(8, bq, 0, -1, 0, 4'h7, -1, 1'b0);
        @(negedge clk);
        check("s4_ok", o_crc_ok, 1'b0);

        // Timeout with DAT idle high.
        got_q.delete();
        run_block(5, bq, -1, -1, 0, 4'hF, -1, 1'b0);
        @(negedge clk);
        check("s5_to", o_timeout, 1'b1);
        check("s5_nbytes", got_q.size(), 0);

        // Reset mid-DATA, then a good block with i_start poked while busy.
        run_block(8, bq, 2, -1, 0, 4'hF, 5, 1'b0);
        run_block(8, bq, 2, -1, 0, 4'hF, -1, 1'b1);
        @(negedge clk);
        check("s6_ok", o_crc_ok, 1'b1);

        // Randomised blocks.
        for (int t = 0; t < 12; t++) begin
            len = $urandom_range(1, 12);
            bq.delete();
            for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
            run_block(len, bq, $urandom_range(0, T),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                      $urandom_range(0, 15),
                      ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : 4'hF,
                      -1, 1'($urandom_range(0, 1)));
        end

        repeat (4) drive(4'hF, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
